// File: rtl/gpio_seq_pkg.sv
// Shared types and constants for the GPIO step sequencer.
// Holds the FSM encoding and the masked-update helper.
package gpio_seq_pkg;

  localparam int DEF_GPIO_NUM   = 32;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // One output bit after a step: mask selects new data, else keep.
  function automatic logic masked_bit(
    input logic cur,
    input logic data,
    input logic mask
  );
    return mask ? data : cur;
  endfunction

endpackage

// File: rtl/gpio_seq_ctrl_if.sv
// Host-side step command channel (valid/ready).
// Master drives a step, slave (the sequencer) returns ready.
interface gpio_seq_ctrl_if
  import gpio_seq_pkg::*;
#(
  parameter int GPIO_NUM  = DEF_GPIO_NUM,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
);

  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic [GPIO_NUM-1:0]  cmd_data_i;
  logic [GPIO_NUM-1:0]  cmd_mask_i;
  logic [CNT_WIDTH-1:0] cmd_dur_i;
  logic                 cmd_last_i;

  modport master (
    output cmd_valid_i,
    output cmd_data_i,
    output cmd_mask_i,
    output cmd_dur_i,
    output cmd_last_i,
    input  cmd_ready_o
  );

  modport slave (
    input  cmd_valid_i,
    input  cmd_data_i,
    input  cmd_mask_i,
    input  cmd_dur_i,
    input  cmd_last_i,
    output cmd_ready_o
  );

endinterface

// File: rtl/gpio_seq_fifo.sv
// Synchronous FIFO with flush; occupancy kept apart from pointers.
// Depth must be a power of two so pointers wrap naturally.
module gpio_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];
  assign count   = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)
        cnt <= cnt + (AW+1)'(1);
      else if (do_pop && !do_push)
        cnt <= cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/gpio_seq_ctrl.sv
// Timed GPIO output-pattern sequencer: buffers steps and applies
// each masked step to the output word for dur+1 enabled cycles.
module gpio_seq_ctrl
  import gpio_seq_pkg::*;
#(
  parameter int GPIO_NUM   = DEF_GPIO_NUM,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                          hclk,
  input  logic                          hreset,
  input  logic                          en_i,
  input  logic                          clr_i,
  gpio_seq_ctrl_if.slave                cmd,
  output logic [GPIO_NUM-1:0]           gpio_out_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
  output logic                          step_done_o,
  output logic                          seq_done_o,
  output logic                          underrun_o
);

  localparam int EW = 1 + CNT_WIDTH + 2*GPIO_NUM;

  logic [EW-1:0]        wdata;
  logic [EW-1:0]        rdata;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;

  logic [GPIO_NUM-1:0]  hd_data;
  logic [GPIO_NUM-1:0]  hd_mask;
  logic [CNT_WIDTH-1:0] hd_dur;
  logic                 hd_last;

  state_t               state, state_d;
  logic [CNT_WIDTH-1:0] cnt, cnt_d;
  logic [GPIO_NUM-1:0]  gpio_q, gpio_d;
  logic                 last_q, last_d;
  logic                 und_q, und_d;
  logic                 load;
  logic                 step_done;
  logic                 seq_done;

  // Ready never looks at pop, so a full FIFO frees a slot one cycle late.
  assign cmd.cmd_ready_o = !full && !clr_i;
  assign push = cmd.cmd_valid_i && cmd.cmd_ready_o;
  assign wdata = {cmd.cmd_last_i, cmd.cmd_dur_i,
                  cmd.cmd_mask_i, cmd.cmd_data_i};

  assign hd_data = rdata[GPIO_NUM-1:0];
  assign hd_mask = rdata[2*GPIO_NUM-1:GPIO_NUM];
  assign hd_dur  = rdata[2*GPIO_NUM +: CNT_WIDTH];
  assign hd_last = rdata[EW-1];

  gpio_seq_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (hclk),
    .rst   (hreset),
    .flush (clr_i),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt_o)
  );

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state  <= IDLE;
      cnt    <= '0;
      gpio_q <= '0;
      last_q <= 1'b0;
      und_q  <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      gpio_q <= gpio_d;
      last_q <= last_d;
      und_q  <= und_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    gpio_d    = gpio_q;
    last_d    = last_q;
    und_d     = und_q;
    load      = 1'b0;
    pop       = 1'b0;
    step_done = 1'b0;
    seq_done  = 1'b0;
    if (clr_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      und_d   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (en_i && !empty) load = 1'b1;
        end
        HOLD: begin
          if (en_i) begin
            if (cnt != '0) begin
              cnt_d = cnt - CNT_WIDTH'(1);
            end else begin
              step_done = 1'b1;
              if (last_q) begin
                seq_done = 1'b1;
                state_d  = IDLE;
              end else if (!empty) begin
                load = 1'b1;
              end else begin
                und_d   = 1'b1;
                state_d = IDLE;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Pop and apply share one edge, giving back-to-back steps.
    if (load) begin
      pop     = 1'b1;
      state_d = HOLD;
      cnt_d   = hd_dur;
      last_d  = hd_last;
      for (int i = 0; i < GPIO_NUM; i++)
        gpio_d[i] = masked_bit(gpio_q[i], hd_data[i], hd_mask[i]);
    end
  end

  assign gpio_out_o  = gpio_q;
  assign busy_o      = (state == HOLD);
  assign step_done_o = step_done;
  assign seq_done_o  = seq_done;
  assign underrun_o  = und_q;

endmodule

// File: tb/tb_gpio_seq_ctrl.sv
// Bench for gpio_seq_ctrl: directed steps plus random traffic,
// checked every cycle against a queue-based step model.
module tb_gpio_seq_ctrl;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
    logic [15:0] dur;
    logic        last;
  } cmd_t;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        en;
  logic        clr;
  logic [31:0] gpio;
  logic        busy;
  logic [2:0]  fcnt;
  logic        step;
  logic        seq;
  logic        und;

  int compared   = 0;
  int mismatched = 0;

  cmd_t        q[$];
  cmd_t        cur;
  bit          active;
  int          rem;
  logic [31:0] m_gpio;
  bit          m_und;

  int          busy_cycles;
  int          step_n;
  int          seq_n;
  int          cyc;
  int          chg[$];
  logic [31:0] prev_gpio;

  gpio_seq_ctrl_if #(.GPIO_NUM(32), .CNT_WIDTH(16)) cmd_if ();

  gpio_seq_ctrl #(
    .GPIO_NUM   (32),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (16)
  ) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .en_i        (en),
    .clr_i       (clr),
    .cmd         (cmd_if),
    .gpio_out_o  (gpio),
    .busy_o      (busy),
    .fifo_cnt_o  (fcnt),
    .step_done_o (step),
    .seq_done_o  (seq),
    .underrun_o  (und)
  );

  always #5 hclk = ~hclk;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    active = 0;
    rem    = 0;
    m_gpio = '0;
    m_und  = 0;
  endtask

  // One clock edge of the step model, using the inputs the DUT saw.
  task automatic model_update();
    cmd_t inc;
    bit   do_push;
    bit   take;
    take = 0;
    if (hreset) begin
      model_reset();
    end else if (clr) begin
      q.delete();
      active = 0;
      m_und  = 0;
    end else begin
      do_push  = cmd_if.cmd_valid_i && (q.size() < DEPTH);
      inc.data = cmd_if.cmd_data_i;
      inc.mask = cmd_if.cmd_mask_i;
      inc.dur  = cmd_if.cmd_dur_i;
      inc.last = cmd_if.cmd_last_i;
      if (!active) begin
        take = en && (q.size() > 0);
      end else if (en) begin
        rem--;
        if (rem == 0) begin
          if (cur.last) active = 0;
          else if (q.size() > 0) take = 1;
          else begin
            m_und  = 1;
            active = 0;
          end
        end
      end
      if (take) begin
        cur    = q.pop_front();
        m_gpio = (m_gpio & ~cur.mask) | (cur.data & cur.mask);
        rem    = int'(cur.dur) + 1;
        active = 1;
      end
      if (do_push) q.push_back(inc);
    end
  endtask

  task automatic tick();
    bit e_step;
    @(negedge hclk);
    e_step = active && en && (rem == 1) && !clr && !hreset;
    chk("gpio", gpio, m_gpio);
    chk("ready", cmd_if.cmd_ready_o,
        (q.size() < DEPTH) && !clr);
    chk("busy", busy, active);
    chk("fifo_cnt", fcnt, q.size());
    chk("step_done", step, e_step);
    chk("seq_done", seq, e_step && cur.last);
    chk("underrun", und, m_und);
    if (busy) busy_cycles++;
    if (step) step_n++;
    if (seq)  seq_n++;
    if (gpio !== prev_gpio) chg.push_back(cyc);
    prev_gpio = gpio;
    cyc++;
    @(posedge hclk);
    model_update();
    #1;
  endtask

  task automatic clr_stats();
    busy_cycles = 0;
    step_n      = 0;
    seq_n       = 0;
    cyc         = 0;
    chg.delete();
    prev_gpio   = gpio;
  endtask

  task automatic set_cmd(logic [31:0] d, logic [31:0] m,
                         logic [15:0] du, logic l);
    cmd_if.cmd_valid_i = 1'b1;
    cmd_if.cmd_data_i  = d;
    cmd_if.cmd_mask_i  = m;
    cmd_if.cmd_dur_i   = du;
    cmd_if.cmd_last_i  = l;
  endtask

  task automatic drive(logic [31:0] d, logic [31:0] m,
                       logic [15:0] du, logic l);
    set_cmd(d, m, du, l);
    tick();
    cmd_if.cmd_valid_i = 1'b0;
  endtask

  task automatic drain(int bound);
    int n;
    n = 0;
    while ((busy || fcnt != 0) && n < bound) begin
      tick();
      n++;
    end
    chk("drain_idle", {busy, fcnt}, 4'h0);
  endtask

  initial begin
    hreset = 1'b1;
    en     = 1'b0;
    clr    = 1'b0;
    cmd_if.cmd_valid_i = 1'b0;
    cmd_if.cmd_data_i  = '0;
    cmd_if.cmd_mask_i  = '0;
    cmd_if.cmd_dur_i   = '0;
    cmd_if.cmd_last_i  = 1'b0;
    model_reset();
    prev_gpio = '0;
    repeat (2) tick();
    chk("reset_gpio", gpio, 32'h0);
    chk("reset_cnt", fcnt, 3'd0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_und", und, 1'b0);
    hreset = 1'b0;
    tick();

    // Basic single step
    clr_stats();
    en = 1'b1;
    drive(32'h0000_00A5, 32'h0000_00FF, 16'd3, 1'b1);
    tick();
    chk("basic_out", gpio[7:0], 8'hA5);
    drain(20);
    chk("basic_busy", busy_cycles, 4);
    chk("basic_step", step_n, 1);
    chk("basic_seq", seq_n, 1);

    // Masked update
    drive(32'hFFFF_0000, 32'hFFFF_FFFF, 16'd0, 1'b1);
    drain(20);
    drive(32'h0000_FFFF, 32'h0000_00FF, 16'd0, 1'b1);
    drain(20);
    chk("mask_out", gpio, 32'hFFFF_00FF);

    // Back-to-back steps
    clr_stats();
    set_cmd(32'h11, 32'hFF, 16'd0, 1'b0);
    tick();
    set_cmd(32'h22, 32'hFF, 16'd1, 1'b0);
    tick();
    set_cmd(32'h33, 32'hFF, 16'd2, 1'b1);
    tick();
    cmd_if.cmd_valid_i = 1'b0;
    drain(30);
    chk("b2b_busy", busy_cycles, 6);
    chk("b2b_step", step_n, 3);
    chk("b2b_seq", seq_n, 1);
    chk("b2b_nchg", chg.size(), 3);
    if (chg.size() == 3) begin
      chk("b2b_gap1", chg[1] - chg[0], 1);
      chk("b2b_gap2", chg[2] - chg[0], 3);
    end

    // Full FIFO, then underrun
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_cmd(32'h100 + i, 32'hFFF, 16'd1, 1'b0);
      if (i == 4) begin
        chk("full_ready", cmd_if.cmd_ready_o, 1'b0);
        chk("full_cnt", fcnt, 3'd4);
      end
      tick();
    end
    cmd_if.cmd_valid_i = 1'b0;
    en = 1'b1;
    drain(50);
    chk("underrun_set", und, 1'b1);
    repeat (3) tick();
    chk("underrun_sticky", und, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("underrun_clr", und, 1'b0);

    // Pause mid-step
    clr_stats();
    drive(32'h5A5A_5A5A, 32'hFFFF_FFFF, 16'd9, 1'b1);
    tick();
    repeat (3) tick();
    en = 1'b0;
    repeat (5) tick();
    chk("pause_hold", gpio, 32'h5A5A_5A5A);
    chk("pause_busy_mid", busy, 1'b1);
    en = 1'b1;
    drain(40);
    chk("pause_busy", busy_cycles, 15);
    chk("pause_step", step_n, 1);

    // Flush during HOLD
    drive(32'h1234_5678, 32'hFFFF_FFFF, 16'd20, 1'b0);
    tick();
    drive(32'hDEAD_0001, 32'hFFFF_FFFF, 16'd1, 1'b0);
    drive(32'hDEAD_0002, 32'hFFFF_FFFF, 16'd1, 1'b1);
    chk("flush_pre_cnt", fcnt, 3'd2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("flush_cnt", fcnt, 3'd0);
    chk("flush_busy", busy, 1'b0);
    chk("flush_gpio", gpio, 32'h1234_5678);
    repeat (2) tick();

    // Async reset mid-HOLD
    drive(32'hCAFE_F00D, 32'hFFFF_FFFF, 16'd20, 1'b1);
    repeat (2) tick();
    chk("rst_pre_busy", busy, 1'b1);
    #2 hreset = 1'b1;
    #1;
    chk("rst_gpio", gpio, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", fcnt, 3'd0);
    model_reset();
    tick();
    hreset = 1'b0;
    tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 99) < 85);
      clr = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 1) == 1)
        set_cmd($urandom, $urandom,
                16'($urandom_range(0, 3)),
                $urandom_range(0, 3) == 0);
      else
        cmd_if.cmd_valid_i = 1'b0;
      tick();
    end
    clr = 1'b0;
    en  = 1'b1;
    cmd_if.cmd_valid_i = 1'b0;
    drain(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gpio_seq_ctrl.md
Name: gpio_seq_ctrl

Overview:
- Timed output-pattern sequencer for the GPIO block.
- Buffers step commands (data, mask, duration) from a host-side requester via valid/ready.
- Applies each step to a registered GPIO output word for a programmed number of cycles.
- Its gpio_out_o feeds the GPIO pad-out register path, which enables deterministic bit-bang waveforms without per-step CPU intervention.

Parameters:
- GPIO_NUM, 32, width of data/mask/output word.
- FIFO_DEPTH, 4, command buffer entries; power of two, >=2.
- CNT_WIDTH, 16, width of step duration field.

Ports:
- hclk  input  1  clock.
- hreset  input  1  reset; asynchronous, active-high.
- en_i  input  1  run enable; low = pause (no pop, hold counter frozen).
- clr_i  input  1  synchronous flush of FIFO/FSM/flags.
- cmd_valid_i  input  1  command valid.
- cmd_ready_o  output  1  command accepted when valid & ready.
- cmd_data_i  input  GPIO_NUM  output values for the step.
- cmd_mask_i  input  GPIO_NUM  bits to update (1 = take cmd_data_i bit).
- cmd_dur_i  input  CNT_WIDTH  step hold length minus one.
- cmd_last_i  input  1  final step of a sequence.
- gpio_out_o  output  GPIO_NUM  registered output word.
- busy_o  output  1  FSM in HOLD.
- fifo_cnt_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- step_done_o  output  1  one-cycle pulse when a step's hold expires.
- seq_done_o  output  1  one-cycle pulse when a last-flagged step expires.
- underrun_o  output  1  sticky: non-last step expired with FIFO empty.

Behaviour:
- Reset (hreset high, async): gpio_out_o=0, FIFO empty, fifo_cnt_o=0, state IDLE, counter 0, all pulses/flags 0.
- cmd_ready_o = !full && !clr_i. Push at edge where cmd_valid_i & cmd_ready_o. An entry is {last, dur, mask, data}.
- Output update rule: gpio_out <= (gpio_out & ~mask) | (data & mask), registered at pop edge.
- FSM states: IDLE, HOLD.
- IDLE, en_i & !empty: pop, apply step, cnt <= dur, go HOLD. Minimum latency: command pushed at edge N into an idle empty FIFO is applied at edge N+1.
- IDLE otherwise: stay; output holds.
- HOLD, en_i low: cnt frozen, no pop, output holds, busy_o stays 1.
- HOLD, en_i high, cnt != 0: cnt <= cnt-1.
- HOLD, en_i high, cnt == 0: step_done_o=1 for that cycle, then one of:
  - last set: seq_done_o=1, go IDLE.
  - else !empty: pop next step in the same edge (back-to-back, no gap cycle), stay HOLD.
  - else empty: underrun_o <= 1, go IDLE.
- Step occupies exactly dur+1 enabled cycles. dur=0 gives a 1 cycle step; dur=2^CNT_WIDTH-1 gives a 2^CNT_WIDTH cycle step. No wrap: counter only loaded or decremented from nonzero.
- Simultaneous push and pop (not full): occupancy unchanged, data order preserved.
- Full: no push (ready low); pop same cycle frees space next cycle only (ready is not combinationally dependent on pop).
- Empty pop is impossible by construction.
- clr_i: highest priority over push/pop. FIFO emptied, state IDLE, cnt 0, underrun_o cleared, pending pulses suppressed; gpio_out_o retained.
- Reset mid-HOLD returns all to reset values immediately.
- Read/write pointers wrap modulo FIFO_DEPTH; occupancy counted separately (full = cnt==FIFO_DEPTH).

Decomposition:
- Package gpio_seq_pkg: state enum (IDLE, HOLD), default width constants, helper function for the masked update.
- Sub-module gpio_seq_fifo: parameterised sync FIFO (width, depth) with push/pop/full/empty/count and synchronous flush. Same hclk/hreset.

Test Plan:
- Basic step: en=1, push {data=0xA5, mask=0xFF, dur=3, last=1} -> gpio_out_o[7:0]=0xA5 one cycle after acceptance, busy 4 cycles, step_done_o and seq_done_o pulse on the 4th, then IDLE.
- Mask: gpio_out=0xFFFF_0000; step data=0x0000_FFFF, mask=0x0000_00FF -> gpio_out_o=0xFFFF_00FF.
- Back-to-back: 3 steps dur=0,1,2, last on third, pushed while busy -> outputs change at cycles t, t+1, t+3 with no gap; three step_done_o pulses, one seq_done_o.
- Full/underrun: push 5 cmds at DEPTH=4 with en=0 -> ready low after 4, fifo_cnt_o=4. Then run a non-last final step -> underrun_o=1 sticky until clr_i.
- Pause: en_i low for 5 cycles mid dur=9 step -> step lasts 15 cycles total, output unchanged during pause.
- Flush/reset: clr_i during HOLD with 2 queued -> fifo_cnt_o=0, IDLE, output retained. hreset mid-HOLD -> gpio_out_o=0 asynchronously.
